proc_wbuf: RTL
==============

// Module: proc_wbuf
// PURPOSE
//  Write-data holding buffer on the processor-memory side of the write router.
//  While the router FSM sits in BLOCKED, it absorbs the blocked W burst, forwards
//  it to the processor memory and drains it.
//  It produces the router's proc_full and block_fin inputs, and consumes routers_ps and block_ack.
// PARAMETERS
//  DATA_WIDTH   32  W-channel data width; each entry stores {wlast, wdata}
//  DEPTH        16  entries; must be a power of 2, >=4
//  AF_MARGIN    2   proc_full asserts when count >= DEPTH-AF_MARGIN
// PORTS
//  clk         in   1             clock; everything on posedge
//  rst         in   1             synchronous reset, active-high
//  routers_ps  in   3             router present state; 3'b001 = BLOCKED
//  block_ack   in   1             router acknowledge of block_fin
//  s_wvalid    in   1             incoming W beat valid
//  s_wdata     in   DATA_WIDTH    incoming W data
//  s_wlast     in   1             incoming last beat of burst
//  s_wready    out  1             buffer accepts beat
//  m_wvalid    out  1             beat to processor memory valid
//  m_wdata     out  DATA_WIDTH    head entry data
//  m_wlast     out  1             head entry last flag
//  m_wready    in   1             processor memory accepts beat
//  proc_full   out  1             registered almost-full to router
//  block_fin   out  1             blocked burst fully drained
//  count       out  $clog2(DEPTH)+1  occupancy
// BEHAVIOUR
//  - Reset (rst=1 at posedge): state IDLE; pointers and count are 0; all outputs are 0.
//    rst mid-burst discards all contents.
//  - FSM states:
//    - IDLE -> FILL when routers_ps==3'b001.
//    - FILL -> DRAIN on a push with s_wlast=1.
//    - DRAIN -> DONE when count becomes 0 (last entry popped with m_wlast=1).
//    - DONE -> IDLE when block_ack=1.
//  - DONE holds block_fin=1 until block_ack is seen.
//    The router loops block_ack=block_fin, so block_fin is a one-cycle pulse in the system.
//  - Push: s_wready = (state==FILL) & (count<DEPTH).
//    The beat is written at the posedge where s_wvalid & s_wready.
//  - Pop: m_wvalid = (state in FILL,DRAIN) & (count!=0).
//    m_wdata/m_wlast come from the head entry; the entry is popped at the posedge where m_wvalid & m_wready.
//  - Latency: a beat pushed at edge N is presented on m_w* from cycle N+1 (cut-through while in FILL).
//  - Simultaneous push and pop in the same cycle: count unchanged, both pointers advance.
//  - Full (count==DEPTH): s_wready=0 with no overflow; pops continue, so a burst > DEPTH beats cannot deadlock.
//  - Empty: m_wvalid=0; m_wdata is don't-care.
//  - Pointers are log2(DEPTH) bits and wrap naturally DEPTH-1 -> 0.
//    count is one bit wider; the only legal deltas are -1, 0 and +1.
//  - proc_full is registered:
//    next value = (count_next >= DEPTH-AF_MARGIN) | (state_next==DRAIN) | (state_next==DONE).
//    The router must not merge or reroute new traffic into a busy buffer.
//  - s_wvalid with s_wlast in IDLE/DRAIN/DONE is ignored (s_wready=0).
//  - routers_ps leaving 3'b001 while in FILL or DRAIN is a protocol violation.
//    Response: flush the pointers, set count=0, go to IDLE with no block_fin.
// CONFIGURATION
//  PROC_WBUF_ERR_EN defined:
//   - Adds port err_sticky (out, 1), reset 0.
//   - It sets one cycle after a protocol violation, or after a push attempt (s_wvalid=1) in DRAIN.
//   - It clears only on rst.
//  PROC_WBUF_ERR_EN undefined: port absent; the violation flush behaviour is identical.
// TESTING
//  1. Reset held 2 cycles, then released -> s_wready=0, m_wvalid=0, proc_full=0, block_fin=0, count=0.
//  2. routers_ps=001; 4-beat burst D0..D3 (wlast on D3), m_wready=1 -> m_w* shows D0..D3 one cycle behind s_w*.
//     block_fin=1 for exactly 1 cycle after the D3 pop; then IDLE.
//  3. DEPTH=16, m_wready=0; push 14 beats -> proc_full=1 the cycle after the 14th push.
//     After 16 pushes, s_wready=0. Raise m_wready -> drain in order, then block_fin.
//  4. 20-beat burst with m_wready toggling 1/0 each cycle -> no lost or duplicated beats.
//     count never exceeds 16; the data order is preserved.
//  5. Push and pop in the same cycle at count=5 -> count stays 5.
//     Pointers wrap 15->0 with no corruption.
//  6. routers_ps drops to 000 mid-FILL with count=3 -> next cycle count=0, state IDLE, block_fin=0.
//     With PROC_WBUF_ERR_EN, err_sticky=1 until rst.

Source files
------------

// File: rtl/proc_wbuf.sv
// Write-data holding buffer that absorbs a blocked W burst and forwards it to processor memory.
// Latency: a beat pushed at edge N is presented on m_w* from cycle N+1 (cut-through while filling).
// Backpressure: s_wready drops when full or outside FILL; m_wready stalls the head without loss.
// Optional build macro PROC_WBUF_ERR_EN adds the err_sticky protocol-error output.
module proc_wbuf #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 16,
    parameter int AF_MARGIN  = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [2:0]              routers_ps,
    input  logic                    block_ack,
    input  logic                    s_wvalid,
    input  logic [DATA_WIDTH-1:0]   s_wdata,
    input  logic                    s_wlast,
    output logic                    s_wready,
    output logic                    m_wvalid,
    output logic [DATA_WIDTH-1:0]   m_wdata,
    output logic                    m_wlast,
    input  logic                    m_wready,
    output logic                    proc_full,
    output logic                    block_fin,
    output logic [$clog2(DEPTH):0]  count
`ifdef PROC_WBUF_ERR_EN
    ,
    output logic                    err_sticky
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C    = CW'(DEPTH);
    localparam logic [CW-1:0] AF_LEVEL_C = CW'(DEPTH - AF_MARGIN);
    localparam logic [2:0]    PS_BLOCKED = 3'b001;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FILL,
        ST_DRAIN,
        ST_DONE
    } state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            proc_full_q, proc_full_d;
    logic [DATA_WIDTH:0] mem_q [DEPTH];
    logic [DATA_WIDTH:0] head;

    logic blocked;
    logic push;
    logic pop;
    logic violation;

`ifdef PROC_WBUF_ERR_EN
    logic err_q, err_d;
`endif

    // Handshakes and head-entry presentation; data is zeroed when nothing is valid.
    always_comb begin
        blocked   = (routers_ps == PS_BLOCKED);
        s_wready  = (state_q == ST_FILL) && (count_q < DEPTH_C);
        m_wvalid  = ((state_q == ST_FILL) || (state_q == ST_DRAIN)) && (count_q != '0);
        push      = s_wvalid && s_wready;
        pop       = m_wvalid && m_wready;
        violation = ((state_q == ST_FILL) || (state_q == ST_DRAIN)) && !blocked;
        head      = mem_q[rd_ptr_q];
        m_wdata   = m_wvalid ? head[DATA_WIDTH-1:0] : '0;
        m_wlast   = m_wvalid ? head[DATA_WIDTH] : 1'b0;
        block_fin = (state_q == ST_DONE);
        proc_full = proc_full_q;
        count     = count_q;
    end

    // Next-state, pointer and occupancy update; a protocol violation flushes everything.
    always_comb begin
        state_d  = state_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;

        if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        case (state_q)
            ST_IDLE: begin
                if (blocked) begin
                    state_d = ST_FILL;
                end
            end
            ST_FILL: begin
                if (push && s_wlast) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                // No pushes happen here, so the last pop is the one leaving a single entry.
                if (pop && (count_q == CW'(1))) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (block_ack) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (violation) begin
            state_d  = ST_IDLE;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end

        // Busy buffer looks full to the router so it never merges new traffic into it.
        proc_full_d = (count_d >= AF_LEVEL_C) || (state_d == ST_DRAIN) || (state_d == ST_DONE);
    end

`ifdef PROC_WBUF_ERR_EN
    // Sticky error: protocol violation or a push attempt while draining.
    always_comb begin
        err_d = err_q || violation || ((state_q == ST_DRAIN) && s_wvalid);
    end

    assign err_sticky = err_q;
`endif

    // Control state registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            proc_full_q <= 1'b0;
`ifdef PROC_WBUF_ERR_EN
            err_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            proc_full_q <= proc_full_d;
`ifdef PROC_WBUF_ERR_EN
            err_q       <= err_d;
`endif
        end
    end

    // Storage array: each entry holds {wlast, wdata}; contents need no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {s_wlast, s_wdata};
        end
    end

endmodule
